nes_joypad: RTL and testbench



---
 rtl/nes_pkg.sv | 87 ++++++++
 rtl/nes_joypad_joy_shift.sv | 38 +++
 rtl/nes_joypad.sv | 171 +++++++++++++++++
 tb/tb_nes_joypad.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared definitions for the NES joypad block: button bit positions,
// PS/2 set-2 scancodes, decoder state encoding and the key map itself.
package nes_pkg;

    // Bit positions inside a joy byte; {Right, Left, Down, Up, Start, Select, B, A}
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Prefix bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Port 1 letter keys
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_V     = 8'h2A;

    // Port 2 letter keys
    localparam logic [7:0] SC_K     = 8'h42;
    localparam logic [7:0] SC_L     = 8'h4B;
    localparam logic [7:0] SC_I     = 8'h43;
    localparam logic [7:0] SC_O     = 8'h44;

    // Direction codes: with E0 prefix they are the arrow keys (port 1),
    // without prefix they are the numeric keypad (port 2).
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    // Button mask covering both controllers
    typedef struct packed {
        logic [7:0] joy2;
        logic [7:0] joy1;
    } btn_mask_t;

    // Buttons addressed by a code received without the E0 prefix
    function automatic btn_mask_t map_plain(input logic [7:0] code);
        btn_mask_t m;
        m = '0;
        case (code)
            SC_Z:     m.joy1[BTN_A]      = 1'b1;
            SC_X:     m.joy1[BTN_B]      = 1'b1;
            SC_C:     m.joy1[BTN_SELECT] = 1'b1;
            SC_V:     m.joy1[BTN_START]  = 1'b1;
            SC_K:     m.joy2[BTN_A]      = 1'b1;
            SC_L:     m.joy2[BTN_B]      = 1'b1;
            SC_I:     m.joy2[BTN_SELECT] = 1'b1;
            SC_O:     m.joy2[BTN_START]  = 1'b1;
            SC_UP:    m.joy2[BTN_UP]     = 1'b1;
            SC_DOWN:  m.joy2[BTN_DOWN]   = 1'b1;
            SC_LEFT:  m.joy2[BTN_LEFT]   = 1'b1;
            SC_RIGHT: m.joy2[BTN_RIGHT]  = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

    // Buttons addressed by a code received after the E0 prefix
    function automatic btn_mask_t map_ext(input logic [7:0] code);
        btn_mask_t m;
        m = '0;
        case (code)
            SC_UP:    m.joy1[BTN_UP]     = 1'b1;
            SC_DOWN:  m.joy1[BTN_DOWN]   = 1'b1;
            SC_LEFT:  m.joy1[BTN_LEFT]   = 1'b1;
            SC_RIGHT: m.joy1[BTN_RIGHT]  = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/nes_joypad_joy_shift.sv
// Serial controller shift register for one NES port. Parallel load while
// strobe is active, shift right on each read with a fill bit entering at
// bit 7 so reads past the eighth return the fill value.
module joy_shift (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    input  logic       fill,
    output logic [7:0] sr_q
);

    logic [7:0] sr_reg;
    logic [7:0] sr_next;

    // Load has priority; load and shift are mutually exclusive in practice
    always_comb begin
        sr_next = sr_reg;
        if (load) begin
            sr_next = load_data;
        end else if (shift) begin
            sr_next = {fill, sr_reg[7:1]};
        end
    end

    // Register update
    always_ff @(posedge clock) begin
        if (reset) begin
            sr_reg <= 8'h00;
        end else begin
            sr_reg <= sr_next;
        end
    end

    assign sr_q = sr_reg;

endmodule

// File: rtl/nes_joypad.sv
// PS/2 keyboard to dual NES controller bridge. Decodes the make/break
// scancode stream into two live button bytes and serves them to the CPU
// through the $4016/$4017 strobe-and-shift protocol.
module nes_joypad
    import nes_pkg::*;
#(
    parameter logic       READ_FILL = 1'b1,
    parameter logic [6:0] OPEN_BUS  = 7'b0100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] kbd_data,
    input  logic       kbd_data_en,
    input  logic       cpu_sel,
    input  logic       cpu_a0,
    input  logic       cpu_read,
    input  logic       cpu_write,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic [7:0] joy1,
    output logic [7:0] joy2
);

    // ------------------------------------------------------------------
    // Scancode decoder
    // ------------------------------------------------------------------
    kbd_state_t state_reg;
    kbd_state_t state_next;
    btn_mask_t  set_mask;
    btn_mask_t  clr_mask;
    btn_mask_t  joy_reg;
    btn_mask_t  joy_next;

    // Decoder state register; reset drops any pending prefix
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Prefix tracking: E0 and F0 only matter as leading bytes
    always_comb begin
        state_next = state_reg;
        if (kbd_data_en) begin
            case (state_reg)
                ST_IDLE: begin
                    if (kbd_data == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (kbd_data == SC_BRK) begin
                        state_next = ST_BRK;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (kbd_data == SC_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Button actions: make codes set bits, break codes clear them.
    // Prefix bytes map to nothing, so they never touch the masks.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (kbd_data_en) begin
            case (state_reg)
                ST_IDLE:    set_mask = map_plain(kbd_data);
                ST_EXT:     set_mask = map_ext(kbd_data);
                ST_BRK:     clr_mask = map_plain(kbd_data);
                ST_EXT_BRK: clr_mask = map_ext(kbd_data);
                default: begin
                    set_mask = '0;
                    clr_mask = '0;
                end
            endcase
        end
    end

    assign joy_next = (joy_reg & ~clr_mask) | set_mask;

    // Live button state for both ports
    always_ff @(posedge clock) begin
        if (reset) begin
            joy_reg <= '0;
        end else begin
            joy_reg <= joy_next;
        end
    end

    assign joy1 = joy_reg.joy1;
    assign joy2 = joy_reg.joy2;

    // ------------------------------------------------------------------
    // Controller port interface
    // ------------------------------------------------------------------
    logic            strobe_reg;
    logic            strobe_next;
    logic            wr_strobe;
    logic            rd_en;
    logic            load_en;
    logic            rd_bit;
    logic [7:0]      cpu_rdata_reg;
    logic [1:0][7:0] port_joy;
    logic [1:0][7:0] sr_q;
    logic [1:0]      shift_en;
    logic            unused_wdata;

    // Only bit 0 of a $4016 write carries the strobe; $4017 writes go to the APU
    assign wr_strobe    = cpu_sel & cpu_write & ~cpu_a0;
    assign strobe_next  = wr_strobe ? cpu_wdata[0] : strobe_reg;
    assign rd_en        = cpu_sel & cpu_read;
    assign unused_wdata = ^cpu_wdata[7:1];

    // Reload every cycle while strobe is high, except on the cycle that
    // drops it: the registers keep what the previous cycle loaded.
    assign load_en = strobe_reg & ~(wr_strobe & ~cpu_wdata[0]);

    assign port_joy[0] = joy_reg.joy1;
    assign port_joy[1] = joy_reg.joy2;

    // Shared strobe register
    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_reg <= 1'b0;
        end else begin
            strobe_reg <= strobe_next;
        end
    end

    // One shift register per port; only the addressed port shifts on a read
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign shift_en[gi] = rd_en & ~strobe_reg & (cpu_a0 == (gi == 1));

            joy_shift u_shift (
                .clock     (clock),
                .reset     (reset),
                .load      (load_en),
                .load_data (port_joy[gi]),
                .shift     (shift_en[gi]),
                .fill      (READ_FILL),
                .sr_q      (sr_q[gi])
            );
        end
    endgenerate

    // While strobed the controller reports the live A button directly
    assign rd_bit = strobe_reg ? port_joy[cpu_a0][BTN_A] : sr_q[cpu_a0][0];

    // Registered read data, held until the next read
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rdata_reg <= {OPEN_BUS, 1'b0};
        end else if (rd_en) begin
            cpu_rdata_reg <= {OPEN_BUS, rd_bit};
        end
    end

    assign cpu_rdata = cpu_rdata_reg;

endmodule

// File: tb/tb_nes_joypad.sv
// Directed bench for nes_joypad: scancode decoding, strobe/shift protocol,
// port independence and reset behaviour.
module tb_nes_joypad;

    logic       clock;
    logic       reset;
    logic [7:0] kbd_data;
    logic       kbd_data_en;
    logic       cpu_sel;
    logic       cpu_a0;
    logic       cpu_read;
    logic       cpu_write;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic [7:0] joy1;
    logic [7:0] joy2;

    int n_vec = 0;
    int n_bad = 0;

    nes_joypad dut (
        .clock       (clock),
        .reset       (reset),
        .kbd_data    (kbd_data),
        .kbd_data_en (kbd_data_en),
        .cpu_sel     (cpu_sel),
        .cpu_a0      (cpu_a0),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .joy1        (joy1),
        .joy2        (joy2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%02h expected=%02h", n_vec, tag, obs, exp);
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        kbd_data    = b;
        kbd_data_en = 1'b1;
        @(posedge clock);
        #1;
        kbd_data_en = 1'b0;
    endtask

    task automatic cpu_wr(input logic a0, input logic [7:0] d);
        cpu_sel   = 1'b1;
        cpu_a0    = a0;
        cpu_write = 1'b1;
        cpu_wdata = d;
        @(posedge clock);
        #1;
        cpu_sel   = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic a0, output logic [7:0] r);
        cpu_sel  = 1'b1;
        cpu_a0   = a0;
        cpu_read = 1'b1;
        @(posedge clock);
        #1;
        cpu_sel  = 1'b0;
        cpu_read = 1'b0;
        r = cpu_rdata;
    endtask

    logic [7:0] rd;
    logic [9:0] seq1;

    initial begin
        reset       = 1'b1;
        kbd_data    = 8'h00;
        kbd_data_en = 1'b0;
        cpu_sel     = 1'b0;
        cpu_a0      = 1'b0;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        cpu_wdata   = 8'h00;
        idle();
        idle();
        reset = 1'b0;
        idle();

        // Reset state
        check("reset_joy1", joy1, 8'h00);
        check("reset_joy2", joy2, 8'h00);
        check("reset_rdata", cpu_rdata, 8'h40);

        // Plain make/break on port 1
        send_byte(8'h1A);
        check("make_Z_joy1", joy1, 8'h01);
        send_byte(8'h22);
        check("make_X_joy1", joy1, 8'h03);
        send_byte(8'hF0);
        send_byte(8'h1A);
        check("brk_Z_joy1", joy1, 8'h02);
        check("brk_Z_joy2", joy2, 8'h00);

        // Ignored bytes in IDLE
        send_byte(8'hAA);
        send_byte(8'hFA);
        check("ignored_joy1", joy1, 8'h02);

        // Extended versus plain 75
        send_byte(8'hE0);
        send_byte(8'h75);
        check("ext_up_joy1", joy1, 8'h12);
        check("ext_up_joy2", joy2, 8'h00);
        send_byte(8'h75);
        check("kp_up_joy2", joy2, 8'h10);
        check("kp_up_joy1", joy1, 8'h12);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("ext_brk_joy1", joy1, 8'h02);
        check("ext_brk_joy2", joy2, 8'h10);

        // Clear everything, then A + Right on port 1
        send_byte(8'hF0); send_byte(8'h22);
        send_byte(8'hF0); send_byte(8'h75);
        check("cleared_joy1", joy1, 8'h00);
        check("cleared_joy2", joy2, 8'h00);
        send_byte(8'h1A);
        send_byte(8'hE0);
        send_byte(8'h74);
        check("a_right_joy1", joy1, 8'h81);

        // Latch and read out ten bits of port 1
        cpu_wr(1'b0, 8'h01);
        idle();
        cpu_wr(1'b0, 8'h00);
        seq1 = 10'b1110000001;   // bit i = expected read i
        for (int i = 0; i < 10; i++) begin
            cpu_rd(1'b0, rd);
            check($sformatf("p1_read%0d", i), rd, {7'b0100000, seq1[i]});
        end

        // Strobe held: live A bit, no shift
        cpu_wr(1'b0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            cpu_rd(1'b0, rd);
            check($sformatf("strobe_read%0d", i), rd, 8'h41);
        end
        send_byte(8'hF0);
        send_byte(8'h1A);
        cpu_rd(1'b0, rd);
        check("strobe_released", rd, 8'h40);
        cpu_wr(1'b0, 8'h00);

        // Port independence: joy1 = 80 (Right), joy2 = 02 (B)
        send_byte(8'h4B);
        check("l_joy2", joy2, 8'h02);
        cpu_wr(1'b0, 8'h01);
        idle();
        cpu_wr(1'b0, 8'h00);
        cpu_wr(1'b1, 8'h01);     // APU write must not touch strobe
        cpu_rd(1'b0, rd); check("il_p1_0", rd, 8'h40);
        cpu_rd(1'b1, rd); check("il_p2_0", rd, 8'h40);
        cpu_rd(1'b0, rd); check("il_p1_1", rd, 8'h40);
        cpu_rd(1'b1, rd); check("il_p2_1", rd, 8'h41);
        cpu_rd(1'b0, rd); check("il_p1_2", rd, 8'h40);
        cpu_rd(1'b1, rd); check("il_p2_2", rd, 8'h40);

        // Reset mid-prefix drops the E0
        send_byte(8'hE0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        check("midrst_rdata", cpu_rdata, 8'h40);
        send_byte(8'h75);
        check("midrst_joy2", joy2, 8'h10);
        check("midrst_joy1", joy1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
